simplerisc_seq_ctrl: RTL and testbench
======================================

# simplerisc_seq_ctrl

Multi-cycle sequencer for the SimpleRISC datapath. It replaces the free-running `pc <= pc + 4` loop with a FETCH/DECODE/EXECUTE/MEM/WB state machine that:
- owns the PC;
- handshakes with instruction and data memories;
- resolves branches, call and ret;
- generates register-file, flag and memory strobes.

It sits between the existing `control_unit` decode flags and the datapath enables. It traps on halt or on a memory timeout.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_TIMEOUT, 16, maximum wait cycles for imem_ack/dmem_ack before FAULT (>= 2)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction valid, one-cycle pulse
- ir_we  out  1  latch instruction register
- is_ld, is_st, is_wb, is_cmp, is_beq, is_bgt, is_ubranch, is_call, is_ret, is_halt  in  1 each  decoded flags, stable from DECODE onward
- flag_e, flag_gt  in  1  flags register outputs
- branch_target  in  32  pc-relative target from datapath
- ret_addr  in  32  contents of r15
- alu_en  out  1  ALU operand/result capture
- flags_we  out  1  flags register write
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete, one-cycle pulse
- reg_we  out  1  register file write
- wb_sel  out  2  0 = ALU result, 1 = load data, 2 = pc+4
- pc  out  32  current instruction address, also imem address
- halted  out  1  HALT state reached
- fault  out  1  FAULT state reached
- state  out  3  current state code

## Operation
State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, FAULT=6.

- **FETCH:** imem_req=1, held until imem_ack. On ack, ir_we=1 for that cycle, then DECODE.
- **DECODE:** one cycle, no strobes. If is_halt, go to HALT; otherwise EXECUTE.
- **EXECUTE:** one cycle, alu_en=1; flags_we=is_cmp. Next state:
  - MEM if is_ld|is_st;
  - else WB if is_wb|is_call;
  - else FETCH.
- **MEM:**
  - dmem_req=1, dmem_we=is_st, held until dmem_ack.
  - On ack, go to WB if is_ld, else FETCH.
- **WB:** one cycle, reg_we=1, then FETCH.
  - wb_sel=1 if is_ld.
  - wb_sel=2 if is_call; the datapath forces rd=15.
  - wb_sel=0 otherwise.
  - wb_sel=0 in all other states.
- **HALT, FAULT:** terminal; all strobes 0 and pc frozen. halted/fault=1 respectively. Only rst exits.
- **Branch resolution:** evaluated in EXECUTE, registered into a 1-bit taken flag.
  - taken = is_ubranch | is_call | is_ret | (is_beq & flag_e) | (is_bgt & flag_gt).
- **PC update:** only on the edge leaving the instruction, i.e. entering FETCH from EXECUTE, MEM or WB.
  - pc <= taken ? (is_ret ? ret_addr : branch_target) : pc + 4.
  - pc holds the old value during WB so that wb_sel=2 writes old pc+4.
  - pc+4 wraps modulo 2^32.
- **Timeout counter:** width $clog2(MEM_TIMEOUT)+1.
  - Clears on state entry and on ack.
  - Increments each FETCH/MEM cycle with no ack.
  - When count == MEM_TIMEOUT-1 with no ack, the next state is FAULT.
  - An ack on that same cycle wins.

## Timing
- **Reset values:**
  - state=FETCH, pc=RESET_PC, counter=0, taken=0.
  - All strobes 0 (imem_req, ir_we, alu_en, flags_we, dmem_req, dmem_we, reg_we); wb_sel=0.
  - halted=0, fault=0.
- **First request:** imem_req asserts in the first cycle after rst deasserts.
- **Outputs:** all are Moore decodes of registered state, no combinational path from ack to req. Exception: ir_we = (state==FETCH) & imem_ack.
- **Zero-wait-state latency:** ALU op 4 cycles (F, D, E, W), load 5, store 4, non-call branch 3, call 4.
- **Wait states:** each wait cycle adds one cycle.
- **Spurious acks:** acks outside the matching state are ignored.
- **Reset mid-operation:** rst in any state (including MEM with dmem_req high) drops all requests at that edge and restarts at FETCH/RESET_PC. The memory side discards the pending transfer.

## Structure
- **Package simplerisc_pkg:**
  - state enum and encodings;
  - wb_sel codes (WB_ALU, WB_LD, WB_PC4);
  - default RESET_PC.
- **Sub-module simplerisc_mem_timeout:** parameterised wait counter with clear, enable and expired outputs. It is shared by FETCH and MEM.
- **Top level:** the FSM, PC register and taken flag live in simplerisc_seq_ctrl.

## Test plan
- **ALU op, zero wait:** reset, then imem_ack tied 1 with is_wb=1 → states 0,1,2,4,0; reg_we one cycle in WB; pc 0→4 entering FETCH.
- **Load with dmem_ack delayed 3 cycles:** dmem_req high 4 cycles with dmem_we=0; then WB with wb_sel=1; total 8 cycles; pc=4.
- **Branches:**
  - beq with flag_e=1, branch_target=0x40 → pc=0x40 after 3 cycles.
  - beq with flag_e=0 → pc=4.
  - call at pc=0x10 → wb_sel=2 in WB, pc=branch_target.
  - ret with ret_addr=0x14 → pc=0x14.
- **Timeout, MEM_TIMEOUT=16:**
  - imem_ack never asserted → FAULT after 16 FETCH cycles; fault=1; imem_req=0.
  - Ack on the 16th cycle instead → DECODE.
- **Halt and reset:**
  - is_halt → HALT; halted=1; pc frozen for 20 cycles.
  - rst during MEM → next cycle state=FETCH, pc=RESET_PC, dmem_req=0.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the SimpleRISC multi-cycle sequencer.
package simplerisc_pkg;

    // Sequencer states; the numeric codes are visible on the state port.
    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StHalt    = 3'd5,
        StFault   = 3'd6
    } seq_state_e;

    // Register-file write-back source select.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_LD  = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch decision for the instruction currently in EXECUTE.
    function automatic logic branch_taken(
        input logic is_ubranch,
        input logic is_call,
        input logic is_ret,
        input logic is_beq,
        input logic is_bgt,
        input logic flag_e,
        input logic flag_gt
    );
        return is_ubranch | is_call | is_ret | (is_beq & flag_e) | (is_bgt & flag_gt);
    endfunction

endpackage

// File: rtl/simplerisc_mem_timeout.sv
// Wait-state counter shared by the FETCH and MEM handshakes; flags the last allowed cycle.
module simplerisc_mem_timeout #(
    parameter int unsigned MaxCount = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MaxCount) + 1;
    localparam logic [CntW-1:0] LastCount = CntW'(MaxCount - 1);

    logic [CntW-1:0] count_d, count_q;

    // Clear has priority so a state change or ack always restarts the window.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expired means this is the final cycle that may still see an ack.
    assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/simplerisc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer: owns the PC, handshakes with
// instruction and data memory, resolves branches and drives datapath strobes.
module simplerisc_seq_ctrl
    import simplerisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    input  logic        is_ld,
    input  logic        is_st,
    input  logic        is_wb,
    input  logic        is_cmp,
    input  logic        is_beq,
    input  logic        is_bgt,
    input  logic        is_ubranch,
    input  logic        is_call,
    input  logic        is_ret,
    input  logic        is_halt,
    input  logic        flag_e,
    input  logic        flag_gt,
    input  logic [31:0] branch_target,
    input  logic [31:0] ret_addr,
    output logic        alu_en,
    output logic        flags_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state
);

    seq_state_e  state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic        taken_d, taken_q;

    logic taken_now;
    logic taken_sel;
    logic ack_hit;
    logic wait_cycle;
    logic tmo_clr;
    logic tmo_expired;

    assign taken_now = branch_taken(is_ubranch, is_call, is_ret, is_beq, is_bgt,
                                    flag_e, flag_gt);

    // Leaving EXECUTE straight to FETCH happens before taken_q is loaded.
    assign taken_sel = (state_q == StExecute) ? taken_now : taken_q;

    assign ack_hit    = ((state_q == StFetch) & imem_ack) | ((state_q == StMem) & dmem_ack);
    assign wait_cycle = ((state_q == StFetch) & ~imem_ack) | ((state_q == StMem) & ~dmem_ack);
    assign tmo_clr    = (state_d != state_q) | ack_hit;

    simplerisc_mem_timeout #(
        .MaxCount (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmo_clr),
        .en_i      (wait_cycle),
        .expired_o (tmo_expired)
    );

    // Next-state, branch flag and PC update.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        pc_d    = pc_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    state_d = StDecode;
                end else if (tmo_expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                state_d = is_halt ? StHalt : StExecute;
            end
            StExecute: begin
                taken_d = taken_now;
                if (is_ld | is_st) begin
                    state_d = StMem;
                end else if (is_wb | is_call) begin
                    state_d = StWb;
                end else begin
                    state_d = StFetch;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = is_ld ? StWb : StFetch;
                end else if (tmo_expired) begin
                    state_d = StFault;
                end
            end
            StWb: begin
                state_d = StFetch;
            end
            StHalt, StFault: begin
                state_d = state_q;
            end
            default: begin
                state_d = StFault;
            end
        endcase

        // PC advances only as an instruction retires, so WB still sees the old pc.
        if ((state_d == StFetch) &&
            ((state_q == StExecute) || (state_q == StMem) || (state_q == StWb))) begin
            if (taken_sel) begin
                pc_d = is_ret ? ret_addr : branch_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // State, PC and taken registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    // Moore strobes; rst gates them so nothing is requested while in reset.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        alu_en   = 1'b0;
        flags_we = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        halted   = 1'b0;
        fault    = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                StExecute: begin
                    alu_en   = 1'b1;
                    flags_we = is_cmp;
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_st;
                end
                StWb: begin
                    reg_we = 1'b1;
                    if (is_ld) begin
                        wb_sel = WB_LD;
                    end else if (is_call) begin
                        wb_sel = WB_PC4;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                end
                StHalt:   halted = 1'b1;
                StFault:  fault  = 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: tb/tb_simplerisc_seq_ctrl.sv
// Directed self-checking bench for simplerisc_seq_ctrl.
module tb_simplerisc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, ir_we;
    logic        is_ld, is_st, is_wb, is_cmp, is_beq, is_bgt, is_ubranch, is_call, is_ret;
    logic        is_halt, flag_e, flag_gt;
    logic [31:0] branch_target, ret_addr;
    logic        alu_en, flags_we, dmem_req, dmem_we, dmem_ack, reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        halted, fault;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    simplerisc_seq_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .ir_we         (ir_we),
        .is_ld         (is_ld),
        .is_st         (is_st),
        .is_wb         (is_wb),
        .is_cmp        (is_cmp),
        .is_beq        (is_beq),
        .is_bgt        (is_bgt),
        .is_ubranch    (is_ubranch),
        .is_call       (is_call),
        .is_ret        (is_ret),
        .is_halt       (is_halt),
        .flag_e        (flag_e),
        .flag_gt       (flag_gt),
        .branch_target (branch_target),
        .ret_addr      (ret_addr),
        .alu_en        (alu_en),
        .flags_we      (flags_we),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; dmem_ack = 0;
        is_ld = 0; is_st = 0; is_wb = 0; is_cmp = 0; is_beq = 0; is_bgt = 0;
        is_ubranch = 0; is_call = 0; is_ret = 0; is_halt = 0;
        flag_e = 0; flag_gt = 0;
        branch_target = 32'h0; ret_addr = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if ({imem_req, ir_we, alu_en, flags_we, dmem_req, dmem_we, reg_we} !== 7'b0)
            begin errors++; $display("FAIL reset_strobes: imem_req=%b reg_we=%b want 0", imem_req, reg_we); end
        checks++; if ({wb_sel, halted, fault} !== 4'b0)
            begin errors++; $display("FAIL reset_misc: wb_sel=%0d halted=%b fault=%b want 0", wb_sel, halted, fault); end
        rst = 0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
    endtask

    task automatic test_alu();
        do_reset();
        is_wb = 1; imem_ack = 1;
        #1;
        checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL alu_ir_we: got %b want 1", ir_we); end
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL alu_decode: got %0d want 1", state); end
        checks++; if (ir_we !== 1'b0) begin errors++; $display("FAIL alu_spurious_ir_we: got %b want 0", ir_we); end
        imem_ack = 0;
        tick();
        checks++; if (state !== 3'd2 || alu_en !== 1'b1 || flags_we !== 1'b0)
            begin errors++; $display("FAIL alu_exec: state=%0d alu_en=%b flags_we=%b want 2/1/0", state, alu_en, flags_we); end
        tick();
        checks++; if (state !== 3'd4 || reg_we !== 1'b1 || wb_sel !== 2'd0 || pc !== 32'h0)
            begin errors++; $display("FAIL alu_wb: state=%0d reg_we=%b wb_sel=%0d pc=%h want 4/1/0/0", state, reg_we, wb_sel, pc); end
        tick();
        checks++; if (state !== 3'd0 || pc !== 32'h4 || reg_we !== 1'b0)
            begin errors++; $display("FAIL alu_done: state=%0d pc=%h reg_we=%b want 0/4/0", state, pc, reg_we); end
    endtask

    // Continues from pc=4 left by test_alu.
    task automatic test_cmp();
        is_wb = 0; is_cmp = 1; imem_ack = 1;
        tick();
        imem_ack = 0;
        tick();
        checks++; if (flags_we !== 1'b1) begin errors++; $display("FAIL cmp_flags_we: got %b want 1", flags_we); end
        tick();
        checks++; if (state !== 3'd0 || pc !== 32'h8)
            begin errors++; $display("FAIL cmp_done: state=%0d pc=%h want 0/8", state, pc); end
        is_cmp = 0;
    endtask

    task automatic test_load_wait();
        do_reset();
        is_ld = 1; imem_ack = 1;
        tick();
        imem_ack = 0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0)
                begin errors++; $display("FAIL ld_mem%0d: state=%0d req=%b we=%b want 3/1/0", i, state, dmem_req, dmem_we); end
            if (i == 3) dmem_ack = 1;
            tick();
        end
        dmem_ack = 0;
        checks++; if (state !== 3'd4 || wb_sel !== 2'd1 || reg_we !== 1'b1)
            begin errors++; $display("FAIL ld_wb: state=%0d wb_sel=%0d reg_we=%b want 4/1/1", state, wb_sel, reg_we); end
        tick();
        checks++; if (state !== 3'd0 || pc !== 32'h4)
            begin errors++; $display("FAIL ld_done: state=%0d pc=%h want 0/4", state, pc); end
    endtask

    task automatic test_branches();
        // beq taken
        do_reset();
        is_beq = 1; flag_e = 1; branch_target = 32'h40; imem_ack = 1;
        tick(); tick(); tick();
        checks++; if (state !== 3'd0 || pc !== 32'h40)
            begin errors++; $display("FAIL beq_taken: state=%0d pc=%h want 0/40", state, pc); end
        // beq not taken
        do_reset();
        is_beq = 1; flag_e = 0; branch_target = 32'h40; imem_ack = 1;
        tick(); tick(); tick();
        checks++; if (state !== 3'd0 || pc !== 32'h4)
            begin errors++; $display("FAIL beq_not_taken: state=%0d pc=%h want 0/4", state, pc); end
        // bgt taken
        do_reset();
        is_bgt = 1; flag_gt = 1; branch_target = 32'h24; imem_ack = 1;
        tick(); tick(); tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL bgt_taken: pc=%h want 24", pc); end
        // ubranch to 0x10, then call at 0x10
        do_reset();
        is_ubranch = 1; branch_target = 32'h10; imem_ack = 1;
        tick(); tick(); tick();
        is_ubranch = 0; is_call = 1; branch_target = 32'h80;
        tick(); tick(); tick();
        checks++; if (state !== 3'd4 || wb_sel !== 2'd2 || reg_we !== 1'b1 || pc !== 32'h10)
            begin errors++; $display("FAIL call_wb: state=%0d wb_sel=%0d reg_we=%b pc=%h want 4/2/1/10", state, wb_sel, reg_we, pc); end
        tick();
        checks++; if (state !== 3'd0 || pc !== 32'h80)
            begin errors++; $display("FAIL call_done: state=%0d pc=%h want 0/80", state, pc); end
        // ret
        is_call = 0; is_ret = 1; ret_addr = 32'h14; branch_target = 32'h200;
        tick(); tick(); tick();
        checks++; if (state !== 3'd0 || pc !== 32'h14)
            begin errors++; $display("FAIL ret: state=%0d pc=%h want 0/14", state, pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        is_ret = 1; ret_addr = 32'hFFFF_FFFC; imem_ack = 1;
        tick(); tick(); tick();
        is_ret = 0;
        tick(); tick(); tick();
        checks++; if (state !== 3'd0 || pc !== 32'h0)
            begin errors++; $display("FAIL pc_wrap: state=%0d pc=%h want 0/0", state, pc); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL tmo_fetch%0d: state=%0d want 0", k, state); end
            tick();
        end
        checks++; if (state !== 3'd6 || fault !== 1'b1 || imem_req !== 1'b0)
            begin errors++; $display("FAIL tmo_fault: state=%0d fault=%b req=%b want 6/1/0", state, fault, imem_req); end
        // ack on the last allowed cycle wins
        do_reset();
        for (int k = 1; k <= 15; k++) tick();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL tmo_ack_wins: state=%0d want 1", state); end
        // data side timeout
        do_reset();
        is_st = 1; imem_ack = 1;
        tick();
        imem_ack = 0;
        tick(); tick();
        for (int k = 1; k <= 16; k++) tick();
        checks++; if (state !== 3'd6 || dmem_req !== 1'b0 || fault !== 1'b1)
            begin errors++; $display("FAIL tmo_mem: state=%0d dmem_req=%b fault=%b want 6/0/1", state, dmem_req, fault); end
    endtask

    task automatic test_halt();
        do_reset();
        is_halt = 1; imem_ack = 1; branch_target = 32'h100;
        tick(); tick();
        checks++; if (state !== 3'd5 || halted !== 1'b1)
            begin errors++; $display("FAIL halt_enter: state=%0d halted=%b want 5/1", state, halted); end
        for (int k = 0; k < 20; k++) begin
            imem_ack = k[0]; dmem_ack = ~k[0];
            tick();
            checks++; if (state !== 3'd5 || pc !== 32'h0 || imem_req !== 1'b0 || dmem_req !== 1'b0)
                begin errors++; $display("FAIL halt_hold%0d: state=%0d pc=%h want 5/0", k, state, pc); end
        end
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        is_wb = 1; imem_ack = 1;
        tick(); tick(); tick(); tick();
        is_wb = 0; is_st = 1;
        tick();
        imem_ack = 0;
        tick(); tick();
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc !== 32'h4)
            begin errors++; $display("FAIL st_mem: state=%0d req=%b we=%b pc=%h want 3/1/1/4", state, dmem_req, dmem_we, pc); end
        rst = 1;
        tick();
        checks++; if (state !== 3'd0 || pc !== 32'h0 || dmem_req !== 1'b0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL rst_mem: state=%0d pc=%h dmem_req=%b want 0/0/0", state, pc, dmem_req); end
        rst = 0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_restart: req=%b want 1", imem_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_cmp();
        test_load_wait();
        test_branches();
        test_pc_wrap();
        test_timeout();
        test_halt();
        test_reset_in_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
